// File: rtl/mod_port.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit word-addressed registers.
// Independent AW/W capture, byte strobes, OKAY/SLVERR responses, single outstanding write.
module mod_port #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic [2:0]        awprot_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [2:0]        arprot_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  typedef logic [IdxW-1:0] idx_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a >> (IdxW + 2)) == '0;
  endfunction

  function automatic idx_t addr_idx(input logic [ADDR_W-1:0] a);
    return a[IdxW+1:2];
  endfunction

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_held_q, w_held_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rdy_en_q;
  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];

  logic aw_hs, w_hs, ar_hs;
  logic unused_prot;

  assign unused_prot = ^{awprot_i, arprot_i};

  // Readies are held low during reset and come up one edge after it is released.
  assign awready_o = rdy_en_q && !aw_held_q && !bvalid_q;
  assign wready_o  = rdy_en_q && !w_held_q && !bvalid_q;
  assign arready_o = rdy_en_q && !rvalid_q;

  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i && wready_o;
  assign ar_hs = arvalid_i && arready_o;

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end

    // Both halves held: commit and raise the response in the same edge.
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (addr_ok(awaddr_q)) begin
        bresp_d = 2'b00;
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) begin
            regs_d[addr_idx(awaddr_q)][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end else begin
        bresp_d = 2'b10;
      end
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end
    // Reads sample regs_q, so a same-edge write is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (addr_ok(araddr_i)) begin
        rdata_d = regs_q[addr_idx(araddr_i)];
        rresp_d = 2'b00;
      end else begin
        rdata_d = '0;
        rresp_d = 2'b10;
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rdy_en_q  <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rdy_en_q  <= 1'b1;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_mod_port.sv
// Directed bench for mod_port: vector table of single transactions plus
// hand-timed sequences for latency, channel skew, backpressure and reset.
module tb_mod_port;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_port #(.ADDR_W(32), .NUM_REGS(16)) dut (
    .aclk_i   (clk),
    .areset_i (areset),
    .awaddr_i (awaddr),
    .awprot_i (awprot),
    .awvalid_i(awvalid),
    .awready_o(awready),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .bresp_o  (bresp),
    .bvalid_o (bvalid),
    .bready_i (bready),
    .araddr_i (araddr),
    .arprot_i (arprot),
    .arvalid_i(arvalid),
    .arready_o(arready),
    .rdata_o  (rdata),
    .rresp_o  (rresp),
    .rvalid_o (rvalid),
    .rready_i (rready)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // All tasks start and end at a negedge; inputs change and outputs are sampled there.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk); n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("wr_bvalid_seen", 32'(bvalid), 1);
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid_latency", 32'(rvalid), 1);
    d = rdata; resp = rresp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int nb;

    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hA5A5_1234, 4'hF, 2'b00};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'hA5A5_1234, 4'h0, 2'b00};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 2'b10};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 2'b10};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'b00};
    vecs[5]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'b1000, 2'b00};
    vecs[6]  = '{1'b0, 32'h0000_0005, 32'h1100_0000, 4'h0, 2'b00};
    vecs[7]  = '{1'b1, 32'h0000_003C, 32'hFFFF_FFFF, 4'h0, 2'b00};
    vecs[8]  = '{1'b0, 32'h0000_003C, 32'h0000_0000, 4'h0, 2'b00};
    vecs[9]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'hF, 2'b00};
    vecs[10] = '{1'b0, 32'h0000_003F, 32'hCAFE_F00D, 4'h0, 2'b00};
    vecs[11] = '{1'b1, 32'h1000_0008, 32'h0BAD_0BAD, 4'hF, 2'b10};
    vecs[12] = '{1'b0, 32'h0000_0008, 32'hA5A5_1234, 4'h0, 2'b00};
    vecs[13] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 2'b10};

    areset = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    areset = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 32'(awready), 1);
    chk("post_rst_wready", 32'(wready), 1);
    chk("post_rst_arready", 32'(arready), 1);

    // AW+W same edge T: bvalid after T+1, readies back after B handshake at T+2
    awaddr = 32'h18; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("lat_bvalid_T", 32'(bvalid), 0);
    chk("lat_awready_held", 32'(awready), 0);
    @(negedge clk);
    chk("lat_bvalid_T1", 32'(bvalid), 1);
    chk("lat_bresp_T1", 32'(bresp), 0);
    chk("lat_wready_bvalid", 32'(wready), 0);
    @(negedge clk);
    chk("lat_bvalid_T2", 32'(bvalid), 0);
    chk("lat_awready_T2", 32'(awready), 1);
    chk("lat_wready_T2", 32'(wready), 1);
    rd(32'h18, d, r);
    chk("lat_rdata", d, 32'h1234_5678);

    // W three cycles before AW, partial strobes into reg 3
    wdata = 32'hFFFF_FFFF; wstrb = 4'b0101; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    chk("wfirst_wready_held", 32'(wready), 0);
    chk("wfirst_bvalid0", 32'(bvalid), 0);
    @(negedge clk);
    chk("wfirst_bvalid1", 32'(bvalid), 0);
    @(negedge clk);
    awaddr = 32'h0C; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      nb += int'(bvalid);
      if (i == 1) chk("wfirst_bresp", 32'(bresp), 0);
      @(negedge clk);
    end
    chk("wfirst_single_b", nb, 1);
    rd(32'h0C, d, r);
    chk("wfirst_rdata", d, 32'h00FF_00FF);

    // B backpressure
    awaddr = 32'h10; wdata = 32'h0BAD_CAFE; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bhold_bvalid", 32'(bvalid), 1);
      chk("bhold_bresp", 32'(bresp), 0);
      chk("bhold_awready", 32'(awready), 0);
      chk("bhold_wready", 32'(wready), 0);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    chk("bhold_release", 32'(bvalid), 0);

    // R backpressure
    araddr = 32'h10; arvalid = 1; rready = 0;
    @(negedge clk);
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("rhold_rvalid", 32'(rvalid), 1);
      chk("rhold_rdata", rdata, 32'h0BAD_CAFE);
      chk("rhold_arready", 32'(arready), 0);
      @(negedge clk);
    end
    rready = 1;
    @(negedge clk);
    chk("rhold_release", 32'(rvalid), 0);

    // Read and write of reg 2 committing on the same edge
    wr(32'h08, 32'h1, 4'hF, r);
    chk("same_wr1_bresp", 32'(r), 0);
    awaddr = 32'h08; wdata = 32'h2; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    araddr = 32'h08; arvalid = 1; rready = 1;
    @(negedge clk);
    arvalid = 0;
    chk("same_rvalid", 32'(rvalid), 1);
    chk("same_rdata_old", rdata, 32'h1);
    chk("same_bvalid", 32'(bvalid), 1);
    @(negedge clk);
    rd(32'h08, d, r);
    chk("same_rdata_new", d, 32'h2);

    // Table of single transactions
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
      end else begin
        rd(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].data);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
      end
    end

    // Reset while bvalid is high and a read is outstanding
    awaddr = 32'h14; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("rstmid_bvalid_pre", 32'(bvalid), 1);
    araddr = 32'h14; arvalid = 1; rready = 0;
    @(negedge clk);
    chk("rstmid_rvalid_pre", 32'(rvalid), 1);
    areset = 1;
    @(negedge clk);
    chk("rstmid_bvalid", 32'(bvalid), 0);
    chk("rstmid_rvalid", 32'(rvalid), 0);
    areset = 0; arvalid = 0; bready = 1; rready = 1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rd(32'(i * 4), d, r);
      chk($sformatf("rstmid_reg%0d", i), d, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_port.md
# mod_port

AXI4-Lite slave register file exposing NUM_REGS 32-bit read/write registers. Sits behind an AXI4-Lite master as a generic memory-mapped peripheral. It is the standard target for exercising master, monitor and slave agent wiring. It supports independent write-address and write-data acceptance, byte strobes, and OKAY/SLVERR responses.

## Interface
- ADDR_W, 32, address width of awaddr/araddr
- NUM_REGS, 16, number of 32-bit registers, word-addressed from 0x0 (power of two, 2..256)
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous reset, active-high
- awaddr  in  ADDR_W  write address
- awprot  in  3  ignored
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes; bit i enables wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arprot  in  3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response: 00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready

## Operation
- Register index = addr[2+$clog2(NUM_REGS)-1:2]. addr[1:0] is ignored.
- Any set address bit at or above 2+$clog2(NUM_REGS) makes the access out of range.
- Write path: the AW and W channels are captured independently into holding registers, each with a "held" flag.
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
  - Handshake occurs when valid && ready at a rising edge.
- When aw_held and w_held are both set:
  - In range: update only the strobed bytes of the register, bresp=00.
  - Out of range: no register changes, bresp=10.
  - In both cases, set bvalid and clear both held flags.
  - wstrb=0 in range still completes with OKAY and leaves the data unchanged.
- bvalid stays high, with bresp stable, until the bready handshake.
- Only one write is outstanding at a time.
- Read path: arready = !rvalid.
  - On an AR handshake, register rdata and rresp and set rvalid.
  - In range: rdata = register contents, rresp=00.
  - Out of range: rdata=0, rresp=10.
  - rdata and rresp hold stable until the rready handshake, which clears rvalid.
- The read and write paths are fully independent.
- Read and write to the same register on the same edge: the read returns the pre-write value.
- Reset: all registers clear to 0 and all held flags clear. All outputs go to 0 (awready, wready and arready go to 1 on the first cycle after reset deasserts).
- Reset mid-transaction discards the pending transaction; bvalid and rvalid drop on that reset edge.

## Timing
- AW and W handshake on edge T: write commits on edge T+1, and bvalid is visible after edge T+1.
- AW at edge T and W at edge T+k: commit and bvalid follow at edge T+k+1. W arriving before AW is symmetric.
- awready and wready reassert the cycle after the B handshake edge. Back-to-back writes therefore need at least 3 cycles each.
- AR handshake on edge T: rvalid is visible after edge T (1-cycle latency). arready stays low until the R handshake.
- With rready held high, a new read can be accepted every 2 cycles.
- While bvalid or rvalid is held waiting for the ready signal, no internal state changes on that channel.
- All outputs are registered or derived only from internal flags; there is no combinational path from inputs to ready signals.

## Test plan
- After reset: write 0xA5A5_1234 to 0x08 (AW and W same cycle, wstrb=F, bready=1). Expect bvalid 2 edges later with bresp=00. Read 0x08 and expect rdata=0xA5A5_1234, rresp=00, one cycle after the AR handshake.
- W issued 3 cycles before AW (wdata 0xFFFF_FFFF, wstrb=4'b0101, addr 0x0C, register previously 0): expect a single B with OKAY. Readback = 0x00FF_00FF.
- Out-of-range write to 0x40 (NUM_REGS=16): expect bresp=10 and no register change. Read 0x40: expect rdata=0, rresp=10.
- bready held low for 5 cycles: expect bvalid and bresp stable, and awready=wready=0 throughout. Same check on the read side with rready low: expect rvalid, rdata and arready stable.
- Simultaneous read and write of register 2 (old value 0x1, new value 0x2): read returns 0x1. A subsequent read returns 0x2.
- Assert areset while bvalid=1 and an AR is pending: after reset, all valids are 0 and every register reads back 0.
